// File: rtl/instr_fetch_if.sv
// Bundles the fetch stage's memory request/response channel, redirect input
// and decode-side handshake.
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high; valid never depends on ready from the same
// channel, and the payload is only meaningful while valid is high. The
// memory response channel has no ready, so a high imem_rsp_valid is always
// consumed.
interface instr_fetch_if #(
  parameter int width = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [width-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [width-1:0] imem_rsp_data;
  logic             redirect_valid;
  logic [width-1:0] redirect_pc;
  logic [width-1:0] current_insrt;
  logic [width-1:0] insrt_pc;
  logic             insrt_valid;
  logic             insrt_ready;

  // Fetch stage side
  modport master (
    output imem_req_valid, imem_req_addr, current_insrt, insrt_pc, insrt_valid,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
           redirect_pc, insrt_ready
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req_valid, imem_req_addr, current_insrt, insrt_pc, insrt_valid,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
           redirect_pc, insrt_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: PC generation, credit-limited word fetches,
// a 2-entry {insn, pc} queue feeding decode, and redirect flushing that drops
// responses to requests issued before the redirect.
module instr_fetch #(
  parameter int               width    = 32,
  parameter logic [width-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus,
  output logic           dbg_state   // 0 = RUN, 1 = FLUSH
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q, state_n;
  logic [width-1:0] fetch_pc_q, fetch_pc_n;
  logic [1:0]       out_q, out_n;          // accepted requests awaiting a response
  logic [1:0]       stale_q, stale_n;      // responses still to be discarded
  logic [1:0]       qcount_q, qcount_n;
  logic [width-1:0] q_insn_q [2];
  logic [width-1:0] q_insn_n [2];
  logic [width-1:0] q_pc_q   [2];
  logic [width-1:0] q_pc_n   [2];
  logic [width-1:0] tag_q    [2];          // PC of each in-flight request, oldest first
  logic [width-1:0] tag_n    [2];

  logic       pop, req_valid, accept, rsp_ok, push, q_wr, t_wr;
  logic [2:0] credit;
  logic [1:0] out_after;

  assign bus.insrt_valid   = (qcount_q != 2'd0);
  assign bus.current_insrt = q_insn_q[0];
  assign bus.insrt_pc      = q_pc_q[0];
  assign bus.imem_req_addr = fetch_pc_q;
  assign bus.imem_req_valid = req_valid;
  assign dbg_state         = (state_q == FLUSH);

  // Handshake decode, credit check, and all next-state values.
  always_comb begin
    pop       = bus.insrt_valid && bus.insrt_ready;
    // In-flight plus queued words must leave room for every response.
    credit    = {1'b0, out_q} + {1'b0, qcount_q} - {2'b00, pop};
    req_valid = (state_q == RUN) && !bus.redirect_valid && (credit < 3'd2);
    accept    = req_valid && bus.imem_req_ready;
    // A response with nothing in flight is a protocol error and is ignored.
    rsp_ok    = bus.imem_rsp_valid && (out_q != 2'd0);
    push      = rsp_ok && (stale_q == 2'd0) && !bus.redirect_valid;
    out_after = out_q - {1'b0, rsp_ok};
    // Write slots: queue occupancy after the pop, tag occupancy after the response.
    q_wr      = (qcount_q != 2'd0) && !pop;
    t_wr      = (out_q != 2'd0) && !rsp_ok;

    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    stale_n    = stale_q;
    out_n      = out_after + {1'b0, accept};
    qcount_n   = qcount_q;
    q_insn_n   = q_insn_q;
    q_pc_n     = q_pc_q;
    tag_n      = tag_q;

    // Tag FIFO follows every counted response, dropped or not.
    if (rsp_ok) begin
      tag_n[0] = tag_q[1];
    end
    if (accept) begin
      tag_n[t_wr] = fetch_pc_q;
    end

    if (bus.redirect_valid) begin
      // Everything still in flight (after this cycle's response) is now stale.
      stale_n    = out_after;
      state_n    = (out_after != 2'd0) ? FLUSH : RUN;
      fetch_pc_n = bus.redirect_pc & ~width'(3);
      qcount_n   = 2'd0;
    end else begin
      if (rsp_ok && (stale_q != 2'd0)) begin
        stale_n = stale_q - 2'd1;
        if ((state_q == FLUSH) && (stale_q == 2'd1)) begin
          state_n = RUN;
        end
      end
      if (accept) begin
        fetch_pc_n = fetch_pc_q + width'(4);
      end
      if (pop) begin
        q_insn_n[0] = q_insn_q[1];
        q_pc_n[0]   = q_pc_q[1];
      end
      if (push) begin
        q_insn_n[q_wr] = bus.imem_rsp_data;
        q_pc_n[q_wr]   = tag_q[0];
      end
      qcount_n = qcount_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State register; reset clears everything, including the queue payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= 2'd0;
      stale_q    <= 2'd0;
      qcount_q   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_insn_q[i] <= '0;
        q_pc_q[i]   <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      out_q      <= out_n;
      stale_q    <= stale_n;
      qcount_q   <= qcount_n;
      q_insn_q   <= q_insn_n;
      q_pc_q     <= q_pc_n;
      tag_q      <= tag_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a latency-programmable memory model with a request
// budget, directed phases, and a scoreboard of expected requests and
// delivered {pc, insn} pairs.
module tb_instr_fetch;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  always #5 clk = ~clk;

  instr_fetch_if #(.width(W)) bus ();

  instr_fetch #(.width(W), .RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  int req_budget = 0;
  int n_pops = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  int t_rel = 0;

  logic [W-1:0]   req_exp_q [$];
  logic [2*W-1:0] exp_q     [$];
  logic [W-1:0]   pend_addr [$];
  int             pend_due  [$];

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_req(input logic [W-1:0] a);
    req_exp_q.push_back(a);
  endtask

  task automatic exp_insn(input logic [W-1:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // ---------------- memory model + monitor ----------------
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
      bus.imem_req_ready = (req_budget > 0);
      #2;
      if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
        req_budget--;
        pend_addr.push_back(bus.imem_req_addr);
        pend_due.push_back(cyc + mem_lat);
        if (req_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_req: got addr %h required no request", bus.imem_req_addr);
        end else begin
          chk("req_addr", bus.imem_req_addr, req_exp_q.pop_front());
        end
      end
      if (!rst && bus.insrt_valid && bus.insrt_ready) begin
        if (n_pops == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        n_pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_insn: got pc %h required no delivery", bus.insrt_pc);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          chk("insrt_pc", bus.insrt_pc, e[2*W-1:W]);
          chk("current_insrt", bus.current_insrt, e[W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_phase(input int lat, input int budget, input logic rdy);
    tick();
    rst = 1'b1;
    mem_lat = lat;
    req_budget = 0;
    bus.insrt_ready = rdy;
    bus.redirect_valid = 1'b0;
    n_pops = 0;
    tick();
    req_budget = budget;
  endtask

  task automatic release_rst();
    tick();
    rst = 1'b0;
    t_rel = cyc;
  endtask

  task automatic redirect(input logic [W-1:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_exp_q.size() != 0 || pend_due.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    n_checks++;
    if (n < 60) n_pass++;
    else $display("FAIL %s_timeout: %0d items outstanding, required 0", name,
                  exp_q.size() + req_exp_q.size());
    repeat (3) tick();
    chk({name, "_drained"}, {31'b0, bus.insrt_valid}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.insrt_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    tick();
    chk("rst_valid", {31'b0, bus.insrt_valid}, 32'h0);
    chk("rst_insn",  bus.current_insrt, 32'h0);
    chk("rst_pc",    bus.insrt_pc, 32'h0);
    chk("rst_state", {31'b0, dbg_state}, 32'h0);

    // Phase 1: streaming, 1-cycle memory
    start_phase(1, 4, 1'b1);
    exp_req(32'h0); exp_req(32'h4); exp_req(32'h8); exp_req(32'hC);
    exp_insn(32'h0); exp_insn(32'h4); exp_insn(32'h8); exp_insn(32'hC);
    release_rst();
    #1;
    chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    chk("first_req_addr",  bus.imem_req_addr, 32'h0);
    wait_idle("stream");
    chk("first_pop_latency", first_pop_cyc - t_rel, 32'd2);
    chk("pop_spacing",       last_pop_cyc - first_pop_cyc, 32'd3);
    chk("pop_count",         n_pops, 32'd4);

    // Phase 2: decode stalls 5 cycles
    start_phase(1, 3, 1'b0);
    exp_req(32'h0); exp_req(32'h4); exp_req(32'h8);
    exp_insn(32'h0); exp_insn(32'h4); exp_insn(32'h8);
    release_rst();
    repeat (4) tick();
    #1;
    chk("stall_valid",     {31'b0, bus.insrt_valid}, 32'h1);
    chk("stall_head_pc",   bus.insrt_pc, 32'h0);
    chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    tick();
    bus.insrt_ready = 1'b1;
    #1;
    chk("resume_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    chk("resume_req_addr",  bus.imem_req_addr, 32'h8);
    wait_idle("stall");

    // Phase 3: redirect with 2 outstanding, 3-cycle memory
    start_phase(3, 4, 1'b1);
    exp_req(32'h0); exp_req(32'h4); exp_req(32'h100); exp_req(32'h104);
    exp_insn(32'h100); exp_insn(32'h104);
    release_rst();
    tick(); tick();
    redirect(32'h100);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("flush_state", {31'b0, dbg_state}, 32'h1);
    tick();
    #1;
    chk("flush_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
    tick();
    #1;
    chk("flush_exit_state", {31'b0, dbg_state}, 32'h0);
    chk("flush_exit_req",   {31'b0, bus.imem_req_valid}, 32'h1);
    chk("flush_exit_addr",  bus.imem_req_addr, 32'h100);
    wait_idle("redirect");

    // Phase 4: redirect coincident with response and pop, then a redirect during FLUSH
    start_phase(3, 6, 1'b1);
    exp_req(32'h0); exp_req(32'h4); exp_req(32'h180); exp_req(32'h184);
    exp_req(32'h200); exp_req(32'h204);
    exp_insn(32'h0); exp_insn(32'h200); exp_insn(32'h204);
    release_rst();
    repeat (4) tick();
    chk("coinc_rsp", {31'b0, bus.imem_rsp_valid}, 32'h1);
    redirect(32'h180);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("coinc_dropped", {31'b0, bus.insrt_valid}, 32'h0);
    chk("coinc_state",   {31'b0, dbg_state}, 32'h0);
    chk("coinc_req",     bus.imem_req_addr, 32'h180);
    tick(); tick();
    redirect(32'h300);
    tick();
    redirect(32'h203);
    #1;
    chk("flush2_state", {31'b0, dbg_state}, 32'h1);
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    #1;
    chk("flush2_exit_state", {31'b0, dbg_state}, 32'h0);
    chk("flush2_exit_addr",  bus.imem_req_addr, 32'h200);
    wait_idle("double_redirect");

    // Phase 5: fetch PC wraps past 0xFFFF_FFFC
    start_phase(1, 0, 1'b1);
    exp_req(32'hFFFF_FFFC); exp_req(32'h0);
    exp_insn(32'hFFFF_FFFC); exp_insn(32'h0);
    release_rst();
    redirect(32'hFFFF_FFFF);
    tick();
    bus.redirect_valid = 1'b0;
    req_budget = 2;
    #1;
    chk("wrap_aligned_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    wait_idle("wrap");

    // Phase 6: asynchronous reset with 2 requests outstanding
    start_phase(3, 4, 1'b1);
    exp_req(32'h0); exp_req(32'h4); exp_req(32'h8); exp_req(32'hC);
    exp_insn(32'h0); exp_insn(32'h4);
    release_rst();
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, bus.insrt_valid}, 32'h0);
    chk("arst_insn",  bus.current_insrt, 32'h0);
    chk("arst_pc",    bus.insrt_pc, 32'h0);
    chk("arst_addr",  bus.imem_req_addr, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("late_rsp_ignored_1", {31'b0, bus.insrt_valid}, 32'h0);
    tick();
    #1;
    chk("late_rsp_ignored_2", {31'b0, bus.insrt_valid}, 32'h0);
    chk("restart_addr",       bus.imem_req_addr, 32'h0);
    exp_req(32'h0); exp_req(32'h4);
    exp_insn(32'h0); exp_insn(32'h4);
    req_budget = 2;
    wait_idle("async_reset");

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the run must always terminate.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
